// File: rtl/multicycle_control.sv
// Multicycle control unit: a 9-state FSM that sequences one instruction
// at a time and decodes datapath controls from the latched opcode.
module multicycle_control #(
   parameter logic [5:0] HALT_OP = 6'b111111
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] op,
   input  logic       Zero,
   output logic       PCWre,
   output logic       IRWre,
   output logic       RegWre,
   output logic       mRD,
   output logic       mWR,
   output logic       InsMemRW,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       DBDataSrc,
   output logic       WrRegDSrc,
   output logic       ExtSel,
   output logic [1:0] RegDst,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp,
   output logic [3:0] State,
   output logic       Halted,
   output logic       IllegalOp
);

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_AL = 4'd2,
      S_WB_AL  = 4'd3,
      S_EXE_BR = 4'd4,
      S_EXE_LS = 4'd5,
      S_MEM    = 4'd6,
      S_WB_L   = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDI  = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b010000;
   localparam logic [5:0] OP_AND   = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTIU = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;

   state_t     state;
   logic [5:0] opcode;

   logic is_add, is_sub, is_addi, is_or, is_and, is_ori;
   logic is_sll, is_slt, is_sltiu, is_sw, is_lw, is_beq;
   logic is_j, is_jr, is_jal, is_halt;
   logic is_alu, is_jump, known;

   // After IF every decode uses the latched opcode, never the live bus.
   assign is_add   = opcode == OP_ADD;
   assign is_sub   = opcode == OP_SUB;
   assign is_addi  = opcode == OP_ADDI;
   assign is_or    = opcode == OP_OR;
   assign is_and   = opcode == OP_AND;
   assign is_ori   = opcode == OP_ORI;
   assign is_sll   = opcode == OP_SLL;
   assign is_slt   = opcode == OP_SLT;
   assign is_sltiu = opcode == OP_SLTIU;
   assign is_sw    = opcode == OP_SW;
   assign is_lw    = opcode == OP_LW;
   assign is_beq   = opcode == OP_BEQ;
   assign is_j     = opcode == OP_J;
   assign is_jr    = opcode == OP_JR;
   assign is_jal   = opcode == OP_JAL;
   assign is_halt  = opcode == HALT_OP;

   assign is_alu = is_add | is_sub | is_addi | is_or | is_and
                 | is_ori | is_sll | is_slt | is_sltiu;
   assign is_jump = is_j | is_jr | is_jal;
   assign known = is_alu | is_jump | is_sw | is_lw
                | is_beq | is_halt;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state  <= S_IF;
         opcode <= '0;
      end else begin
         case (state)
            S_IF: begin
               opcode <= op;
               state  <= S_ID;
            end
            S_ID: begin
               unique case (1'b1)
                  is_halt:       state <= S_HALT;
                  is_beq:        state <= S_EXE_BR;
                  is_lw | is_sw: state <= S_EXE_LS;
                  is_alu:        state <= S_EXE_AL;
                  default:       state <= S_IF;
               endcase
            end
            S_EXE_AL: state <= S_WB_AL;
            S_WB_AL:  state <= S_IF;
            S_EXE_BR: state <= S_IF;
            S_EXE_LS: state <= S_MEM;
            S_MEM:    state <= is_lw ? S_WB_L : S_IF;
            S_WB_L:   state <= S_IF;
            S_HALT:   state <= S_HALT;
            default:  state <= S_IF;
         endcase
      end
   end

   assign State     = state;
   assign InsMemRW  = 1'b1;
   assign IRWre     = state == S_IF;
   assign Halted    = state == S_HALT;
   assign IllegalOp = (state == S_ID) && !known;

   // Exactly one PC update per instruction, in its last state.
   assign PCWre = ((state == S_ID) && (is_jump || !known))
                || (state == S_EXE_BR)
                || ((state == S_MEM) && is_sw)
                || (state == S_WB_AL)
                || (state == S_WB_L);

   assign RegWre = (state == S_WB_AL) || (state == S_WB_L)
                 || ((state == S_ID) && is_jal);

   assign mRD = (state == S_MEM) && is_lw;
   assign mWR = (state == S_MEM) && is_sw;

   assign ALUSrcA   = is_sll;
   assign ALUSrcB   = is_addi | is_ori | is_sltiu | is_lw | is_sw;
   assign ExtSel    = !is_ori;
   assign DBDataSrc = is_lw;
   assign WrRegDSrc = !is_jal;

   always_comb begin
      RegDst = 2'b10;
      if (is_jal)
         RegDst = 2'b00;
      else if (is_addi | is_ori | is_sltiu | is_lw)
         RegDst = 2'b01;
   end

   always_comb begin
      PCSrc = 2'b00;
      if ((state == S_ID) && (is_j | is_jal))
         PCSrc = 2'b11;
      else if ((state == S_ID) && is_jr)
         PCSrc = 2'b10;
      else if ((state == S_EXE_BR) && Zero)
         PCSrc = 2'b01;
   end

   always_comb begin
      ALUOp = 3'b000;
      unique case (1'b1)
         is_sub | is_beq: ALUOp = 3'b001;
         is_sltiu:        ALUOp = 3'b010;
         is_slt:          ALUOp = 3'b011;
         is_sll:          ALUOp = 3'b100;
         is_or | is_ori:  ALUOp = 3'b101;
         is_and:          ALUOp = 3'b110;
         default:         ALUOp = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction model queues
// the expected output vector for each cycle; a negedge monitor compares.
module tb_multicycle_control;

   localparam logic [5:0] ADD   = 6'b000000;
   localparam logic [5:0] SUB   = 6'b000001;
   localparam logic [5:0] ADDI  = 6'b000010;
   localparam logic [5:0] OR_   = 6'b010000;
   localparam logic [5:0] AND_  = 6'b010001;
   localparam logic [5:0] ORI   = 6'b010010;
   localparam logic [5:0] SLL   = 6'b011000;
   localparam logic [5:0] SLT   = 6'b100110;
   localparam logic [5:0] SLTIU = 6'b100111;
   localparam logic [5:0] SW    = 6'b110000;
   localparam logic [5:0] LW    = 6'b110001;
   localparam logic [5:0] BEQ   = 6'b110100;
   localparam logic [5:0] J     = 6'b111000;
   localparam logic [5:0] JR    = 6'b111001;
   localparam logic [5:0] JAL   = 6'b111010;
   localparam logic [5:0] HALT  = 6'b111111;

   typedef struct packed {
      logic [3:0] state;
      logic       pcwre;
      logic       irwre;
      logic       regwre;
      logic       mrd;
      logic       mwr;
      logic       insmemrw;
      logic [1:0] pcsrc;
      logic [1:0] regdst;
      logic [2:0] aluop;
      logic       srca;
      logic       srcb;
      logic       dbd;
      logic       wrd;
      logic       ext;
      logic       halted;
      logic       illegal;
   } out_t;

   logic       CLK, Reset, Zero;
   logic [5:0] op;
   logic       PCWre, IRWre, RegWre, mRD, mWR, InsMemRW;
   logic       ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] ALUOp;
   logic [3:0] State;
   logic       Halted, IllegalOp;

   multicycle_control #(.HALT_OP(HALT)) dut (
      .CLK(CLK), .Reset(Reset), .op(op), .Zero(Zero),
      .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
      .mRD(mRD), .mWR(mWR), .InsMemRW(InsMemRW),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
      .ExtSel(ExtSel), .RegDst(RegDst), .PCSrc(PCSrc),
      .ALUOp(ALUOp), .State(State), .Halted(Halted),
      .IllegalOp(IllegalOp)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   out_t       sb[$];
   int         total = 0;
   int         passed = 0;
   int         cyc = 0;
   logic [5:0] prev_op;

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s t=%0t got=%h want=%h",
                    name, $time, got, want);
   endtask

   function automatic bit known(input logic [5:0] o);
      return o inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT,
                       SLTIU, SW, LW, BEQ, J, JR, JAL, HALT};
   endfunction

   function automatic bit alu(input logic [5:0] o);
      return o inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLL,
                       SLT, SLTIU};
   endfunction

   // Opcode-only fields: these follow whatever opcode is latched.
   function automatic out_t statics(input logic [5:0] o);
      out_t r;
      r = '0;
      r.insmemrw = 1'b1;
      r.regdst = (o == JAL) ? 2'b00 :
                 (o inside {ADDI, ORI, SLTIU, LW}) ? 2'b01 : 2'b10;
      if (o inside {SUB, BEQ})      r.aluop = 3'd1;
      else if (o == SLTIU)          r.aluop = 3'd2;
      else if (o == SLT)            r.aluop = 3'd3;
      else if (o == SLL)            r.aluop = 3'd4;
      else if (o inside {OR_, ORI}) r.aluop = 3'd5;
      else if (o == AND_)           r.aluop = 3'd6;
      r.srca = (o == SLL);
      r.srcb = o inside {ADDI, ORI, SLTIU, LW, SW};
      r.dbd  = (o == LW);
      r.wrd  = (o != JAL);
      r.ext  = (o != ORI);
      return r;
   endfunction

   // Queue one expected vector per cycle of the instruction.
   task automatic expect_instr(input logic [5:0] o, input logic z,
                               input int nhalt, output int n);
      logic [3:0] st[$];
      out_t       e;
      bit         last;
      st.push_back(4'd0);
      st.push_back(4'd1);
      if (o == HALT)
         repeat (nhalt) st.push_back(4'd8);
      else if (o == BEQ) st.push_back(4'd4);
      else if (o == LW) begin
         st.push_back(4'd5); st.push_back(4'd6); st.push_back(4'd7);
      end else if (o == SW) begin
         st.push_back(4'd5); st.push_back(4'd6);
      end else if (alu(o)) begin
         st.push_back(4'd2); st.push_back(4'd3);
      end
      n = st.size();
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         e = statics(i == 0 ? prev_op : o);
         e.state  = st[i];
         e.irwre  = (i == 0);
         e.pcwre  = last && (o != HALT);
         e.regwre = (last && (alu(o) || o == LW))
                  || (i == 1 && o == JAL);
         e.mrd    = (st[i] == 4'd6) && (o == LW);
         e.mwr    = (st[i] == 4'd6) && (o == SW);
         if (i == 1 && o == JR)                  e.pcsrc = 2'b10;
         if (i == 1 && o inside {J, JAL})        e.pcsrc = 2'b11;
         if (st[i] == 4'd4 && z)                 e.pcsrc = 2'b01;
         e.halted  = (st[i] == 4'd8);
         e.illegal = (i == 1) && !known(o);
         sb.push_back(e);
      end
   endtask

   // Called one step after a rising edge with the DUT in IF.
   task automatic issue(input logic [5:0] o, input logic z,
                        input int nhalt);
      int n;
      expect_instr(o, z, nhalt, n);
      op = o;
      Zero = z;
      for (int k = 0; k < n; k++) begin
         @(posedge CLK); #1;
         op = 6'($urandom);
      end
      prev_op = o;
   endtask

   task automatic check_reset(input string name);
      check(name,
            {22'd0, State, IRWre, InsMemRW, PCWre, RegWre,
             mRD, mWR, Halted, IllegalOp},
            {22'd0, 4'd0, 1'b1, 1'b1, 6'b000000});
   endtask

   always @(negedge CLK) begin
      out_t e, a;
      cyc++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = '{State, PCWre, IRWre, RegWre, mRD, mWR, InsMemRW,
               PCSrc, RegDst, ALUOp, ALUSrcA, ALUSrcB, DBDataSrc,
               WrRegDSrc, ExtSel, Halted, IllegalOp};
         check($sformatf("outputs cyc%0d", cyc), 32'(a), 32'(e));
      end
   end

   initial begin
      logic [5:0] r;
      int         n;
      Reset = 1'b0;
      Zero = 1'b0;
      op = 6'b110001;
      prev_op = '0;
      #2;
      check_reset("reset_initial");
      @(posedge CLK); #1;
      check_reset("reset_across_edge");
      Reset = 1'b1;

      issue(ADD, 1'b0, 0);
      issue(LW, 1'b0, 0);
      issue(BEQ, 1'b1, 0);
      issue(BEQ, 1'b0, 0);
      issue(JAL, 1'b0, 0);
      issue(6'b000011, 1'b0, 0);
      issue(SW, 1'b1, 0);
      issue(JR, 1'b0, 0);

      // Pull reset in the middle of an add's write-back cycle.
      expect_instr(ADD, 1'b0, 0, n);
      op = ADD;
      repeat (3) begin
         @(posedge CLK); #1;
         op = 6'($urandom);
      end
      #5;
      Reset = 1'b0;
      #1;
      check_reset("reset_in_wb_al");
      check("reset_in_wb_al_queue", 32'(sb.size()), 32'd0);
      @(posedge CLK); #1;
      check_reset("reset_held");
      Reset = 1'b1;
      prev_op = '0;

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: r = 6'($urandom);
            default: begin
               case ($urandom_range(0, 14))
                  0: r = ADD;   1: r = SUB;   2: r = ADDI;
                  3: r = OR_;   4: r = AND_;  5: r = ORI;
                  6: r = SLL;   7: r = SLT;   8: r = SLTIU;
                  9: r = SW;    10: r = LW;   11: r = BEQ;
                  12: r = J;    13: r = JR;   default: r = JAL;
               endcase
            end
         endcase
         if (r == HALT) r = ADD;
         issue(r, 1'($urandom), 0);
      end

      issue(HALT, 1'($urandom), 12);
      @(negedge CLK); #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL have parameter HALT_OP, default 6'b111111, giving the halt opcode.
REQ-003 The block SHALL have port CLK, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port op, input, 6 bits: instruction[31:26] from instruction memory.
REQ-006 The block SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-007 The block SHALL have outputs PCWre, IRWre, RegWre, mRD, mWR, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc and ExtSel, each 1 bit.
REQ-008 The block SHALL have outputs RegDst (2 bits), PCSrc (2 bits), ALUOp (3 bits) and State (4 bits).
REQ-009 The block SHALL have outputs Halted and IllegalOp, each 1 bit.

Function
REQ-010 The block SHALL encode its states as IF=0, ID=1, EXE_AL=2, WB_AL=3, EXE_BR=4, EXE_LS=5, MEM=6, WB_L=7, HALT=8, and SHALL drive the current state on State.
REQ-011 Any unused state code SHALL go to IF on the next edge.
REQ-012 The block SHALL hold an internal 6-bit opcode register, loaded from op on the clock edge that leaves IF.
REQ-013 All decodes in states after IF SHALL use the opcode register, not op.
REQ-014 The block SHALL support these opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sltiu 100111, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt = HALT_OP.
REQ-015 The block SHALL make these transitions: IF->ID always.
- ID->IF for j, jr, jal and unknown opcodes.
- ID->EXE_BR for beq.
- ID->EXE_LS for lw and sw.
- ID->HALT for halt.
- ID->EXE_AL for all other opcodes.
REQ-016 The block SHALL make these further transitions: EXE_AL->WB_AL->IF; EXE_BR->IF; EXE_LS->MEM; MEM->IF for sw; MEM->WB_L->IF for lw; HALT->HALT.
REQ-017 Instruction latencies SHALL be: j/jr/jal/unknown 2 cycles; beq 3; sw 4; arithmetic/logic 4; lw 5.
REQ-018 All outputs SHALL be combinational decodes of the state and opcode register; Zero SHALL be used only in EXE_BR.
REQ-019 InsMemRW SHALL be constant 1 (read).
REQ-020 IRWre SHALL be 1 only in IF.
REQ-021 PCWre SHALL be 1 for exactly one cycle per instruction, in its final state (ID for j/jr/jal/unknown, EXE_BR, MEM for sw, WB_AL, WB_L), and 0 in every other state including HALT.
REQ-022 PCSrc SHALL be 00 (PC+4) by default, 01 in EXE_BR when Zero=1, 10 for jr, and 11 for j/jal.
REQ-023 RegWre SHALL be 1 only in WB_AL, in WB_L, and in ID for jal.
REQ-024 RegDst SHALL be 00 ($31) for jal, 01 (rt) for addi/ori/sltiu/lw, and 10 (rd) otherwise.
REQ-025 WrRegDSrc SHALL be 0 only for jal; DBDataSrc SHALL be 1 only for lw.
REQ-026 mRD SHALL be 1 only in MEM for lw; mWR SHALL be 1 only in MEM for sw.
REQ-027 ALUSrcA SHALL be 1 only for sll; ALUSrcB SHALL be 1 for addi/ori/sltiu/lw/sw; ExtSel SHALL be 0 only for ori.
REQ-028 ALUOp SHALL be: add/addi/lw/sw 000, sub/beq 001, sltiu 010, slt 011, sll 100, or/ori 101, and 110.
REQ-029 IllegalOp SHALL be 1 only in ID with an unknown opcode; that instruction SHALL act as a nop (PCWre=1, PCSrc=00, no writes).
REQ-030 Halted SHALL be 1 only in HALT; HALT SHALL be left only by Reset, and op changes SHALL be ignored while in HALT.

Reset
REQ-031 Reset low SHALL immediately force State=IF and opcode register=0, independent of CLK and including mid-instruction.
REQ-032 While Reset is low, outputs SHALL be the IF decode: IRWre=1, InsMemRW=1, and PCWre/RegWre/mRD/mWR/Halted/IllegalOp=0.
REQ-033 The first rising edge after Reset goes high SHALL move IF->ID.

Verification
REQ-034 The bench SHALL cover: op=000000 (add) -> State 0,1,2,3,0; RegWre=1 and PCWre=1 only in WB_AL; RegDst=10; ALUOp=000.
REQ-035 The bench SHALL cover: op=110001 (lw) -> State 0,1,5,6,7,0; mRD=1 in MEM; RegWre=1, DBDataSrc=1, RegDst=01 in WB_L.
REQ-036 The bench SHALL cover: op=110100 (beq) with Zero=1 and then Zero=0 -> 3 cycles each; PCSrc=01 and 00 respectively in EXE_BR; ALUOp=001.
REQ-037 The bench SHALL cover: op=111010 (jal) -> 2 cycles; in ID, RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
REQ-038 The bench SHALL cover: Reset low during WB_AL -> State=0 and RegWre=0 before the next edge.
REQ-039 The bench SHALL cover: op=111111 -> HALT with Halted=1 and PCWre=0 for 10+ cycles despite op toggling; op=000011 -> IllegalOp=1 for one cycle and return to IF.
